// File: rtl/jk_pkg.sv
// Shared definitions for the JK flip-flop bank arbiter: command encodings,
// FSM state type and the JK next-state helper used by the readback checker.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StApply,
    StSettle,
    StDone
  } jk_state_e;

  // Value a JK flop takes after one edge with {j,k} = op from current q.
  function automatic logic jk_next(input logic [1:0] op, input logic q);
    logic r;
    case (op)
      JK_HOLD:   r = q;
      JK_RESET:  r = 1'b0;
      JK_SET:    r = 1'b1;
      default:   r = ~q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// (ptr + 1) mod NREQ. The pointer register lives in the parent.
module jk_rr_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid
);

  logic [31:0]    cand;
  logic [IDW-1:0] cand_id;

  // Scan requesters in rotation order starting just after the pointer.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    cand_id   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand    = (32'(ptr) + i) % NREQ;
      cand_id = cand[IDW-1:0];
      if (!gnt_valid && req[cand_id]) begin
        gnt_valid    = 1'b1;
        gnt[cand_id] = 1'b1;
        gnt_id       = cand_id;
      end
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin command arbiter for a shared bank of JK flip-flops.
// Each command drives one flop's j/k for exactly one edge, then returns the
// flop's new q with a one-cycle ack. Optional macro JK_READBACK_CHECK_EN adds
// a sticky readback mismatch flag (err); without it err is tied low.
module jk_bank_arbiter
  import jk_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NFF  = 8,
  parameter int unsigned IDXW = 3,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [IDXW*NREQ-1:0] idx,
  output logic [NREQ-1:0]      ack,
  output logic                 rdata,
  output logic                 busy,
  output logic [IDW-1:0]       gnt_id,
  output logic [NFF-1:0]       j_out,
  output logic [NFF-1:0]       k_out,
  input  logic [NFF-1:0]       q_in,
  output logic                 err
);

  localparam logic [IDXW:0] NffLim = (IDXW + 1)'(NFF);

  function automatic logic in_range(input logic [IDXW-1:0] i);
    return {1'b0, i} < NffLim;
  endfunction

  jk_state_e       state_q, state_d;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  gnt_id_q;
  logic [NREQ-1:0] gnt_oh_q;
  logic [IDXW-1:0] idx_q;
  logic [NFF-1:0]  j_q, k_q;
  logic [NREQ-1:0] ack_q;
  logic            rdata_q;

  logic [NREQ-1:0] arb_gnt;
  logic [IDW-1:0]  arb_id;
  logic            arb_valid;
  logic [1:0]      sel_op;
  logic [IDXW-1:0] sel_idx;
  logic [NFF-1:0]  sel_mask;
  logic            q_sel;

  jk_rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req       (req),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  // Pick out the granted requester's command and decode its target flop.
  always_comb begin
    sel_op   = '0;
    sel_idx  = '0;
    sel_mask = '0;
    for (int unsigned r = 0; r < NREQ; r++) begin
      if (arb_id == IDW'(r)) begin
        sel_op  = op[2*r +: 2];
        sel_idx = idx[IDXW*r +: IDXW];
      end
    end
    if (in_range(sel_idx)) sel_mask[sel_idx] = 1'b1;
  end

  // Current q of the latched target; out-of-range targets read as 0.
  always_comb begin
    q_sel = 1'b0;
    if (in_range(idx_q)) q_sel = q_in[idx_q];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic: fixed four-step sequence once a grant is made.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (arb_valid) state_d = StApply;
      StApply:  state_d = StSettle;
      StSettle: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy = (state_q != StIdle);
  end

  // Grant latching, registered j/k pulse, readback capture and ack pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= IDW'(NREQ - 1);
      gnt_id_q <= '0;
      gnt_oh_q <= '0;
      idx_q    <= '0;
      j_q      <= '0;
      k_q      <= '0;
      ack_q    <= '0;
      rdata_q  <= 1'b0;
    end else begin
      j_q   <= '0;
      k_q   <= '0;
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (arb_valid) begin
            ptr_q    <= arb_id;
            gnt_id_q <= arb_id;
            gnt_oh_q <= arb_gnt;
            idx_q    <= sel_idx;
            // j/k are live during APPLY, so they load on the grant edge.
            j_q      <= sel_op[1] ? sel_mask : '0;
            k_q      <= sel_op[0] ? sel_mask : '0;
          end
        end
        StSettle: begin
          rdata_q <= q_sel;
          ack_q   <= gnt_oh_q;
        end
        default: ;
      endcase
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign gnt_id = gnt_id_q;
  assign j_out  = j_q;
  assign k_out  = k_q;

`ifdef JK_READBACK_CHECK_EN
  logic [1:0] cmd_sel;
  logic       exp_q;
  logic       err_q;

  // Command actually applied to the target, recovered from the j/k pulse.
  always_comb begin
    cmd_sel = 2'b00;
    if (in_range(idx_q)) cmd_sel = {j_q[idx_q], k_q[idx_q]};
  end

  // Predict from pre-command q during APPLY, compare after the bank update.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StApply) exp_q <= jk_next(cmd_sel, q_sel);
      if (state_q == StSettle && in_range(idx_q) && (q_sel != exp_q)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
